// File: rtl/muldiv_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | muldiv_ctrl_pkg: op codes and helpers shared by the mul/div sequencer.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package muldiv_ctrl_pkg;

  typedef logic [1:0] md_op_t;

  localparam md_op_t MD_MULT  = 2'b00;
  localparam md_op_t MD_MULTU = 2'b01;
  localparam md_op_t MD_DIV   = 2'b10;
  localparam md_op_t MD_DIVU  = 2'b11;

  // Two's-complement magnitude; 0x80000000 maps to itself, read as unsigned.
  function automatic logic [31:0] abs32(input logic [31:0] v);
    return v[31] ? (32'd0 - v) : v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/muldiv_ctrl_div_iter.sv
// +--------------------------------------------------------------------------+
// | div_iter: unsigned 32/32 radix-2 restoring divider, one bit per enable.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module div_iter (
  input  logic        clk,
  input  logic        rst,
  input  logic        init_i,
  input  logic        en_i,
  input  logic [31:0] dividend_i,
  input  logic [31:0] divisor_i,
  output logic [31:0] quotient_o,
  output logic [31:0] remainder_o
);

  logic [31:0] quot_q, quot_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [32:0] w_shift;

  // The dividend shifts out of quot_q MSB-first while quotient bits enter at the LSB.
  always_comb begin
    w_shift = {rem_q, quot_q[31]};
    quot_d  = quot_q;
    rem_d   = rem_q;
    dvs_d   = dvs_q;
    if (init_i) begin
      quot_d = dividend_i;
      rem_d  = 32'd0;
      dvs_d  = divisor_i;
    end else if (en_i) begin
      if (w_shift >= {1'b0, dvs_q}) begin
        rem_d  = 32'(w_shift - {1'b0, dvs_q});
        quot_d = {quot_q[30:0], 1'b1};
      end else begin
        rem_d  = w_shift[31:0];
        quot_d = {quot_q[30:0], 1'b0};
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      quot_q <= 32'd0;
      rem_q  <= 32'd0;
      dvs_q  <= 32'd0;
    end else begin
      quot_q <= quot_d;
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
    end
  end

  assign quotient_o  = quot_q;
  assign remainder_o = rem_q;

endmodule

`default_nettype wire

// File: rtl/muldiv_ctrl.sv
// +--------------------------------------------------------------------------+
// | muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer owning HI/LO.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
#(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        flush,
  input  logic        mthi_we,
  input  logic        mtlo_we,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  localparam logic [4:0] MUL_LAST = 5'(MUL_LAT - 1);
  localparam logic [4:0] DIV_LAST = 5'd31;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  md_op_t      op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        w_accept;
  logic        w_is_div;
  logic [31:0] w_a_opnd, w_b_opnd;
  logic        w_div_init, w_div_en;
  logic [31:0] w_quot, w_rem;
  logic        w_sa, w_sb;
  logic [63:0] w_prod;

  assign w_accept = (state_q == S_IDLE) & start & ~flush;
  assign w_is_div = (op == MD_DIV);
  assign w_a_opnd = w_is_div ? abs32(A) : A;
  assign w_b_opnd = w_is_div ? abs32(B) : B;

  // Sign-extending to 64 bits gives the same low half as the 66-bit {s,A}*{s,B}.
  assign w_sa   = ~op_q[0] & a_q[31];
  assign w_sb   = ~op_q[0] & b_q[31];
  assign w_prod = {{32{w_sa}}, a_q} * {{32{w_sb}}, b_q};

  div_iter u_div_iter (
    .clk         (clk),
    .rst         (rst),
    .init_i      (w_div_init),
    .en_i        (w_div_en),
    .dividend_i  (w_a_opnd),
    .divisor_i   (w_b_opnd),
    .quotient_o  (w_quot),
    .remainder_o (w_rem)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    qneg_d     = qneg_q;
    rneg_d     = rneg_q;
    hi_d       = hi_q;
    lo_d       = lo_q;
    done_d     = 1'b0;
    w_div_init = 1'b0;
    w_div_en   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (~flush) begin
          if (mthi_we) hi_d = wdata;
          if (mtlo_we) lo_d = wdata;
        end
        if (w_accept) begin
          op_d       = op;
          a_d        = w_a_opnd;
          b_d        = w_b_opnd;
          qneg_d     = w_is_div & (A[31] ^ B[31]);
          rneg_d     = w_is_div & A[31];
          cnt_d      = 5'd0;
          w_div_init = 1'b1;
          state_d    = op[1] ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == MUL_LAST) state_d = S_FIN;
      end
      S_DIV: begin
        w_div_en = 1'b1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == DIV_LAST) state_d = S_FIN;
      end
      default: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (op_q[1]) begin
          hi_d = rneg_q ? (32'd0 - w_rem)  : w_rem;
          lo_d = qneg_q ? (32'd0 - w_quot) : w_quot;
        end else begin
          hi_d = w_prod[63:32];
          lo_d = w_prod[31:0];
        end
      end
    endcase
    // A flush while busy abandons the operation, including a pending FIN write.
    if (flush && (state_q != S_IDLE)) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 5'd0;
      op_q    <= MD_MULT;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign stall = ~flush & (((state_q == S_IDLE) & start) | (state_q != S_IDLE));
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule

`default_nettype wire

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Multi-cycle multiply/divide sequencer for the EX stage. It sits beside the single-cycle ALU and owns the architectural HI/LO registers. It accepts MULT/MULTU/DIV/DIVU from EX, stalls the pipeline until the result is committed, and services MTHI/MTLO writes. Exception flush cancels any in-flight operation without touching HI/LO.

## Interface
- `MUL_LAT`, default 2: cycles spent in MUL state (legal range 1..15).
- `clk`  in  1  clock; single clock domain.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  EX holds a mul/div instruction.
- `op`  in  2  `MD_MULT`=00, `MD_MULTU`=01, `MD_DIV`=10, `MD_DIVU`=11.
- `A`  in  32  rs operand (dividend / multiplicand).
- `B`  in  32  rt operand (divisor / multiplier).
- `flush`  in  1  exception/eret cancel.
- `mthi_we`, `mtlo_we`  in  1 each  move-to-HI / move-to-LO strobes.
- `wdata`  in  32  data for MTHI/MTLO.
- `stall`  out  1  hold IF..EX; combinational.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `hi`, `lo`  out  32 each  architectural HI/LO, registered.

## Operation
- States: IDLE, MUL, DIV, FIN. 2-bit encoding, localparams.
- **IDLE:** when `start & ~flush`, the operation is accepted:
  - latch `op`;
  - latch the operand magnitudes: `|A|` and `|B|` for DIV, raw values for the others;
  - latch the sign flags: `qneg = A[31]^B[31]`, `rneg = A[31]` (signed divide only);
  - clear `cnt`;
  - go to MUL (`op[1]`=0) or DIV (`op[1]`=1).
- **MUL:** product is 66-bit signed `{s,A}*{s,B}`, where `s` is the sign bit for MULT and 0 for MULTU. Keep the low 64 bits. Increment `cnt`. When `cnt == MUL_LAT-1`, go to FIN.
- **DIV:** radix-2 restoring, one quotient bit per cycle, 32 cycles (`cnt` 0..31). Then go to FIN.
- **FIN:**
  - DIV: negate the quotient if `qneg`; negate the remainder if `rneg`.
  - Write `hi`=remainder/product[63:32] and `lo`=quotient/product[31:0] at the clock edge.
  - Go to IDLE and set the `done` register.
- **Divide by zero:** no exception. The result is the natural restoring result with magnitudes: quotient magnitude 0xFFFFFFFF, remainder magnitude `|A|`. Sign fixup is then applied as usual.
- **Overflow case** 0x80000000 / 0xFFFFFFFF signed: `lo`=0x80000000, `hi`=0. No trap.
- **`stall`** = `(state==IDLE & start & ~flush) | (state!=IDLE & ~flush)`.
- **`flush`** in MUL/DIV/FIN: go to IDLE next cycle. No HI/LO write, no `done`. `flush` beats the FIN write.
- **MTHI/MTLO:**
  - Honoured only in IDLE. Ignored while busy, since the pipeline is stalled and cannot issue them.
  - Both strobes together write both registers.
  - A write in the same IDLE cycle as an accepted `start` is applied; the later FIN overwrites it.
  - Gated by `~flush`.
- **Reset:** state IDLE, `cnt`=0, `hi`=`lo`=0, `done`=0. `stall` = `start` (combinational).
- Reset mid-operation aborts the operation identically to `flush`, but additionally clears HI/LO.

## Timing
- Accept cycle = cycle 0; `stall` is high from cycle 0.
- Multiply:
  - MUL occupies cycles 1..`MUL_LAT`;
  - FIN occupies cycle `MUL_LAT`+1;
  - `done`=1 and new HI/LO are visible in cycle `MUL_LAT`+2 (default: cycle 4);
  - `stall`=0 in that cycle.
- Divide: DIV occupies cycles 1..32, FIN occupies cycle 33, `done` in cycle 34.
- `done` is high for exactly one cycle.
- A new `start` may be accepted in the `done` cycle (back-to-back).
- MTHI/MTLO data is visible on `hi`/`lo` the cycle after the strobe.
- `stall` and the `done`-cycle outputs have no dependency on `A`/`B`. `stall` depends only on `start`, `flush` and state.

## Structure
- Shared header `head.vh` gains:
  - the `MD_*` op codes;
  - the state localparams only if reused elsewhere; otherwise keep them local.
- One sub-module, `div_iter`: unsigned 32/32 restoring divider core.
  - Inputs: `clk`, `rst`, `init`, `en`, dividend, divisor.
  - Outputs: quotient, remainder.
  - One bit per enabled cycle.
- Sign handling and HI/LO stay in `muldiv_ctrl`.
- Multiply uses the inferred `*` on the latched operands, registered at FIN.
- Expected size: ~250 lines total.

## Test plan
- **MULT:** A=0xFFFFFFFE (−2), B=3.
  - Expect `done` at cycle 4; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA.
  - `stall` is high for cycles 0–3.
- **MULTU:** A=B=0xFFFFFFFF.
  - Expect `hi`=0xFFFFFFFE, `lo`=0x00000001.
- **DIV:** A=−7, B=2.
  - Expect `done` at cycle 34; `lo`=0xFFFFFFFD (−3), `hi`=0xFFFFFFFF (−1).
- **Edge divides:**
  - DIVU A=5, B=0 → `lo`=0xFFFFFFFF, `hi`=5.
  - DIV 0x80000000/0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- **Flush:**
  - Preload `hi`=0x11, `lo`=0x22 via MTHI/MTLO.
  - Start DIV, assert `flush` at cycle 20 → IDLE at cycle 21, no `done`, HI/LO unchanged, `stall`=0 at cycle 20.
  - Repeat with `flush` in the FIN cycle → same outcome.
- **Back-to-back and moves:**
  - A second MULTU `start` in the `done` cycle completes 4 cycles later.
  - `mthi_we` with `wdata`=0xABCD during DIV is ignored.
  - `mthi_we` in IDLE → `hi`=0xABCD the next cycle.
